// File: rtl/sm4_pkg.sv
// Shared constants and types for the SM4 block sequencer and its chain datapath.
package sm4_pkg;

  localparam int unsigned BLK_W = 128;
  localparam int unsigned CMD_W = 2;

  localparam logic [CMD_W-1:0] CMD_NOP  = 2'b00;
  localparam logic [CMD_W-1:0] CMD_KEXP = 2'b01;
  localparam logic [CMD_W-1:0] CMD_ENC  = 2'b10;
  localparam logic [CMD_W-1:0] CMD_DEC  = 2'b11;

  localparam logic MODE_ECB = 1'b0;
  localparam logic MODE_CBC = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KISS  = 3'd1,
    ST_KWAIT = 3'd2,
    ST_RDY   = 3'd3,
    ST_BISS  = 3'd4,
    ST_BWAIT = 3'd5,
    ST_OUT   = 3'd6
  } state_e;

  typedef struct packed {
    logic [BLK_W-1:0] data;
    logic             last;
  } blk_beat_t;

endpackage

// File: rtl/sm4_cbc_chain.sv
// CBC chain register with IV load and the core input/output XOR muxing.
module sm4_cbc_chain
  import sm4_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             dir,
  input  logic             iv_load,
  input  logic [BLK_W-1:0] iv,
  input  logic [BLK_W-1:0] blk,
  input  logic [BLK_W-1:0] core_dout,
  input  logic             upd,
  output logic [BLK_W-1:0] din_c,
  output logic [BLK_W-1:0] dout_c
);

  logic [BLK_W-1:0] chain_q, chain_d, chain_eff_c;

  // An IV written in the same cycle as a block launch is bypassed to the encrypt XOR.
  always_comb begin
    chain_eff_c = iv_load ? iv : chain_q;
    din_c       = (mode == MODE_CBC && !dir) ? (blk ^ chain_eff_c) : blk;
    dout_c      = (mode == MODE_CBC && dir) ? (core_dout ^ chain_q) : core_dout;
    chain_d     = chain_q;
    if (iv_load) begin
      chain_d = iv;
    end else if (upd && mode == MODE_CBC) begin
      chain_d = dir ? blk : core_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) chain_q <= '0;
    else        chain_q <= chain_d;
  end

endmodule

// File: rtl/sm4_block_sequencer.sv
// Stream-side SM4 controller: key expansion, then one-block-in-flight ECB/CBC processing.
module sm4_block_sequencer
  import sm4_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_mode,
  input  logic             cfg_dir,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [BLK_W-1:0] key,
  input  logic             iv_load,
  input  logic [BLK_W-1:0] iv,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [BLK_W-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [BLK_W-1:0] m_data,
  output logic             m_last,
  output logic             key_ok,
  output logic             busy,
  output logic             err_timeout,
  output logic [CMD_W-1:0] core_cmd,
  output logic [BLK_W-1:0] core_din,
  input  logic [BLK_W-1:0] core_dout,
  input  logic             core_vld
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_ready_q, key_ready_d, rdy_q, rdy_d, busy_q, busy_d;
  logic             key_ok_q, key_ok_d, err_q, err_d;
  logic             m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [BLK_W-1:0] m_data_q, m_data_d, core_din_q, core_din_d;
  logic [CMD_W-1:0] core_cmd_q, core_cmd_d;
  blk_beat_t        blk_q, blk_d;
  logic             mode_q, mode_d, dir_q, dir_d;

  logic             key_hs_c, blk_hs_c, iv_ld_c, in_rdy_c, timeout_c;
  logic             ch_mode_c, ch_dir_c, ch_upd_c;
  logic [BLK_W-1:0] ch_blk_c, din_c, dout_c;

  // Key reload takes priority: no data accepted while a key is on offer.
  assign s_ready = rdy_q & ~key_valid;

  always_comb begin
    key_hs_c  = key_valid & key_ready_q;
    blk_hs_c  = s_valid & s_ready;
    in_rdy_c  = (state_q == ST_RDY);
    iv_ld_c   = iv_load & (state_q == ST_IDLE || in_rdy_c);
    timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    ch_mode_c = in_rdy_c ? cfg_mode : mode_q;
    ch_dir_c  = in_rdy_c ? cfg_dir : dir_q;
    ch_blk_c  = in_rdy_c ? s_data : blk_q.data;
    ch_upd_c  = (state_q == ST_BWAIT) & core_vld;
  end

  sm4_cbc_chain u_chain (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (ch_mode_c),
    .dir       (ch_dir_c),
    .iv_load   (iv_ld_c),
    .iv        (iv),
    .blk       (ch_blk_c),
    .core_dout (core_dout),
    .upd       (ch_upd_c),
    .din_c     (din_c),
    .dout_c    (dout_c)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    key_ok_d   = key_ok_q;
    err_d      = err_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    blk_d      = blk_q;
    mode_d     = mode_q;
    dir_d      = dir_q;
    core_cmd_d = CMD_NOP;
    core_din_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (key_hs_c) begin
          state_d    = ST_KISS;
          err_d      = 1'b0;
          core_cmd_d = CMD_KEXP;
          core_din_d = key;
        end
      end
      ST_KISS: state_d = ST_KWAIT;
      ST_KWAIT: begin
        if (core_vld) begin
          state_d  = ST_RDY;
          key_ok_d = 1'b1;
        end else if (timeout_c) begin
          state_d  = ST_IDLE;
          err_d    = 1'b1;
          key_ok_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RDY: begin
        if (key_hs_c) begin
          state_d    = ST_KISS;
          key_ok_d   = 1'b0;
          err_d      = 1'b0;
          core_cmd_d = CMD_KEXP;
          core_din_d = key;
        end else if (blk_hs_c) begin
          state_d    = ST_BISS;
          blk_d.data = s_data;
          blk_d.last = s_last;
          mode_d     = cfg_mode;
          dir_d      = cfg_dir;
          core_cmd_d = cfg_dir ? CMD_DEC : CMD_ENC;
          core_din_d = din_c;
        end
      end
      ST_BISS: state_d = ST_BWAIT;
      ST_BWAIT: begin
        if (core_vld) begin
          state_d   = ST_OUT;
          m_valid_d = 1'b1;
          m_data_d  = dout_c;
          m_last_d  = blk_q.last;
        end else if (timeout_c) begin
          state_d  = ST_IDLE;
          err_d    = 1'b1;
          key_ok_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          state_d   = ST_RDY;
          m_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready/busy flags are registered from the next state.
  always_comb begin
    key_ready_d = (state_d == ST_IDLE) || (state_d == ST_RDY);
    rdy_d       = (state_d == ST_RDY);
    busy_d      = ~key_ready_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      key_ready_q <= 1'b1;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
      key_ok_q    <= 1'b0;
      err_q       <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      core_cmd_q  <= CMD_NOP;
      core_din_q  <= '0;
      blk_q       <= '0;
      mode_q      <= MODE_ECB;
      dir_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_ready_q <= key_ready_d;
      rdy_q       <= rdy_d;
      busy_q      <= busy_d;
      key_ok_q    <= key_ok_d;
      err_q       <= err_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      core_cmd_q  <= core_cmd_d;
      core_din_q  <= core_din_d;
      blk_q       <= blk_d;
      mode_q      <= mode_d;
      dir_q       <= dir_d;
    end
  end

  assign key_ready   = key_ready_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_last      = m_last_q;
  assign key_ok      = key_ok_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;
  assign core_cmd    = core_cmd_q;
  assign core_din    = core_din_q;

endmodule
